spi_burst_sequencer: RTL and testbench

Sequencer that runs multi-byte SPI transfers through the SPI master core's 16-bit register port, so no CPU is needed per transaction. It takes a command (byte count and slave mask), a TX byte stream and an RX byte stream. It drives the core's slave-enable, control, status, txdata and rxdata registers: assert SS, move each byte, wait for the shifter to drain, release SS. It sits between a DMA/streaming client and the SPI master, in place of the CPU master on that port.

---
 rtl/spi_seq_pkg.sv | 34 +++
 rtl/spi_reg_access.sv | 61 ++++++
 rtl/spi_burst_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_burst_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_seq_pkg.sv
// Shared constants for the SPI burst sequencer: SPI master core register
// map, status/control bit positions and the sequencer state encoding.
package spi_seq_pkg;

   localparam logic [2:0] ADDR_RXDATA  = 3'd0;
   localparam logic [2:0] ADDR_TXDATA  = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;
   localparam logic [2:0] ADDR_SS      = 3'd5;

   localparam int BIT_ROE  = 3;
   localparam int BIT_TOE  = 4;
   localparam int BIT_TMT  = 5;
   localparam int BIT_RRDY = 7;

   // Control word with only SSO (bit 10) set; every IRQ enable stays 0.
   localparam logic [15:0] CTRL_SSO = 16'h0400;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_SS,
      S_WR_CTRL_ON,
      S_WR_STAT_CLR,
      S_WAIT_TX,
      S_WR_TX,
      S_POLL_R,
      S_RD_RX,
      S_WAIT_RX,
      S_POLL_TMT,
      S_WR_CTRL_OFF,
      S_DONE
   } state_t;

endpackage

// File: rtl/spi_reg_access.sv
// Three-cycle register access engine for the SPI master core port:
// select and strobe held for two cycles with address/data stable, then one
// deasserted cycle. ack marks the second asserted cycle; rdata is the core's
// registered read data, valid to sample on the edge that ends that cycle.
module spi_reg_access (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  addr,
   input  logic [15:0] wdata,
   output logic        ack,
   output logic        active,
   output logic [15:0] rdata,
   output logic        spi_select,
   output logic [2:0]  spi_addr,
   output logic [15:0] spi_wdata,
   output logic        spi_read_n,
   output logic        spi_write_n,
   input  logic [15:0] spi_rdata
);

   logic [1:0] phase;

   // Drive the bus for two cycles per request, then release it for one.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase       <= 2'd0;
         spi_select  <= 1'b0;
         spi_read_n  <= 1'b1;
         spi_write_n <= 1'b1;
         spi_addr    <= 3'd0;
         spi_wdata   <= 16'd0;
      end else begin
         case (phase)
            2'd0: begin
               if (req) begin
                  phase       <= 2'd1;
                  spi_select  <= 1'b1;
                  spi_read_n  <= we;
                  spi_write_n <= ~we;
                  spi_addr    <= addr;
                  spi_wdata   <= we ? wdata : 16'd0;
               end
            end
            2'd1: phase <= 2'd2;
            default: begin
               phase       <= 2'd0;
               spi_select  <= 1'b0;
               spi_read_n  <= 1'b1;
               spi_write_n <= 1'b1;
            end
         endcase
      end
   end

   assign ack    = (phase == 2'd2);
   assign active = (phase != 2'd0);
   assign rdata  = spi_rdata;

endmodule

// File: rtl/spi_burst_sequencer.sv
// SPI burst sequencer: runs a whole multi-byte SPI transfer through the SPI
// master core's register port, one byte in flight at a time.
// Optional watchdog on the wait states: define SPI_SEQ_TIMEOUT_EN.
module spi_burst_sequencer
   import spi_seq_pkg::*;
#(
   parameter int POLL_GAP       = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_len,
   input  logic [15:0] cmd_ss,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        busy,
   output logic        done,
   output logic        done_err,
   output logic        spi_select,
   output logic [2:0]  spi_addr,
   output logic [15:0] spi_wdata,
   output logic        spi_read_n,
   output logic        spi_write_n,
   input  logic [15:0] spi_rdata
);

   state_t      state;
   logic [7:0]  cnt;
   logic [15:0] ss;
   logic [7:0]  tx_byte;
   logic        err;
   logic [3:0]  gap_cnt;

   logic        acc_req, acc_we, acc_ack, acc_active;
   logic [2:0]  acc_addr;
   logic [15:0] acc_wdata, acc_rdata;
   logic        tmo_hit;
   logic        unused_bits;

   spi_reg_access u_acc (
      .clk         (clk),
      .reset       (reset),
      .req         (acc_req),
      .we          (acc_we),
      .addr        (acc_addr),
      .wdata       (acc_wdata),
      .ack         (acc_ack),
      .active      (acc_active),
      .rdata       (acc_rdata),
      .spi_select  (spi_select),
      .spi_addr    (spi_addr),
      .spi_wdata   (spi_wdata),
      .spi_read_n  (spi_read_n),
      .spi_write_n (spi_write_n),
      .spi_rdata   (spi_rdata)
   );

`ifdef SPI_SEQ_TIMEOUT_EN
   logic [15:0] tmo_cnt;
   logic        in_wait;

   assign in_wait = (state == S_WAIT_TX) || (state == S_POLL_R) ||
                    (state == S_POLL_TMT) || (state == S_WAIT_RX);
   // Only fire between accesses so a half-finished bus cycle never leaks
   // its ack into the control-off write.
   assign tmo_hit = in_wait && !acc_active &&
                    ({16'd0, tmo_cnt} >= 32'(TIMEOUT_CYCLES - 1));
   assign unused_bits = ^acc_rdata[15:8];

   // Watchdog: count cycles spent in the current wait state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= 16'd0;
      end else if (!in_wait || (state == S_WAIT_RX && rx_ready)) begin
         tmo_cnt <= 16'd0;
      end else begin
         tmo_cnt <= tmo_cnt + 16'd1;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign tmo_hit     = 1'b0;
   assign unused_bits = ^{acc_active, acc_rdata[15:8]};
`endif

   // One register access request per state; polls pause for the gap count.
   always_comb begin
      acc_req   = 1'b0;
      acc_we    = 1'b0;
      acc_addr  = ADDR_RXDATA;
      acc_wdata = 16'd0;
      case (state)
         S_WR_SS:       begin acc_req = 1'b1; acc_we = 1'b1; acc_addr = ADDR_SS;      acc_wdata = ss; end
         S_WR_CTRL_ON:  begin acc_req = 1'b1; acc_we = 1'b1; acc_addr = ADDR_CONTROL; acc_wdata = CTRL_SSO; end
         S_WR_STAT_CLR: begin acc_req = 1'b1; acc_we = 1'b1; acc_addr = ADDR_STATUS; end
         S_WR_TX:       begin acc_req = 1'b1; acc_we = 1'b1; acc_addr = ADDR_TXDATA;  acc_wdata = {8'h00, tx_byte}; end
         S_POLL_R,
         S_POLL_TMT:    begin acc_req = (gap_cnt == 4'd0) && !tmo_hit; acc_addr = ADDR_STATUS; end
         S_RD_RX:       begin acc_req = 1'b1; acc_addr = ADDR_RXDATA; end
         S_WR_CTRL_OFF: begin acc_req = 1'b1; acc_we = 1'b1; acc_addr = ADDR_CONTROL; end
         default: ;
      endcase
   end

   // Transfer sequencing with registered handshake and status outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         cnt       <= 8'd0;
         ss        <= 16'd0;
         tx_byte   <= 8'd0;
         err       <= 1'b0;
         gap_cnt   <= 4'd0;
         rx_data   <= 8'd0;
         cmd_ready <= 1'b1;
         tx_ready  <= 1'b0;
         rx_valid  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         done_err  <= 1'b0;
      end else begin
         done     <= 1'b0;
         done_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  cnt       <= cmd_len;
                  ss        <= cmd_ss;
                  err       <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_WR_SS;
               end
            end
            S_WR_SS:      if (acc_ack) state <= S_WR_CTRL_ON;
            S_WR_CTRL_ON: if (acc_ack) state <= S_WR_STAT_CLR;
            S_WR_STAT_CLR: begin
               if (acc_ack) begin
                  tx_ready <= 1'b1;
                  state    <= S_WAIT_TX;
               end
            end
            S_WAIT_TX: begin
               if (tx_valid) begin
                  tx_byte  <= tx_data;
                  tx_ready <= 1'b0;
                  state    <= S_WR_TX;
               end else if (tmo_hit) begin
                  err      <= 1'b1;
                  tx_ready <= 1'b0;
                  state    <= S_WR_CTRL_OFF;
               end
            end
            S_WR_TX: begin
               if (acc_ack) begin
                  gap_cnt <= 4'd0;
                  state   <= S_POLL_R;
               end
            end
            S_POLL_R: begin
               if (acc_ack) begin
                  err <= err | acc_rdata[BIT_ROE] | acc_rdata[BIT_TOE];
                  if (acc_rdata[BIT_RRDY]) state <= S_RD_RX;
                  else gap_cnt <= POLL_GAP[3:0];
               end else if (gap_cnt != 4'd0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else if (tmo_hit) begin
                  err   <= 1'b1;
                  state <= S_WR_CTRL_OFF;
               end
            end
            S_RD_RX: begin
               if (acc_ack) begin
                  rx_data  <= acc_rdata[7:0];
                  rx_valid <= 1'b1;
                  state    <= S_WAIT_RX;
               end
            end
            S_WAIT_RX: begin
               if (rx_ready) begin
                  rx_valid <= 1'b0;
                  if (cnt == 8'd0) begin
                     gap_cnt <= 4'd0;
                     state   <= S_POLL_TMT;
                  end else begin
                     cnt      <= cnt - 8'd1;
                     tx_ready <= 1'b1;
                     state    <= S_WAIT_TX;
                  end
               end else if (tmo_hit) begin
                  err      <= 1'b1;
                  rx_valid <= 1'b0;
                  state    <= S_WR_CTRL_OFF;
               end
            end
            S_POLL_TMT: begin
               if (acc_ack) begin
                  err <= err | acc_rdata[BIT_ROE] | acc_rdata[BIT_TOE];
                  if (acc_rdata[BIT_TMT]) state <= S_WR_CTRL_OFF;
                  else gap_cnt <= POLL_GAP[3:0];
               end else if (gap_cnt != 4'd0) begin
                  gap_cnt <= gap_cnt - 4'd1;
               end else if (tmo_hit) begin
                  err   <= 1'b1;
                  state <= S_WR_CTRL_OFF;
               end
            end
            S_WR_CTRL_OFF: begin
               if (acc_ack) begin
                  done     <= 1'b1;
                  done_err <= err;
                  state    <= S_DONE;
               end
            end
            S_DONE: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: begin
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               tx_ready  <= 1'b0;
               rx_valid  <= 1'b0;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer with a behavioural SPI master core model
// (MISO looped to MOSI). Timeout scenario built only with SPI_SEQ_TIMEOUT_EN.
module tb_spi_burst_sequencer;

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int TMO = 64;
`else
   localparam int TMO = 4096;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready;
   logic [7:0]  cmd_len = 8'd0;
   logic [15:0] cmd_ss = 16'd0;
   logic [7:0]  tx_data = 8'd0;
   logic        tx_valid = 1'b0, tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_ready = 1'b1;
   logic        busy, done, done_err;
   logic        spi_select, spi_read_n, spi_write_n;
   logic [2:0]  spi_addr;
   logic [15:0] spi_wdata, spi_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_burst_sequencer #(.POLL_GAP(2), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_ss(cmd_ss),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .done(done), .done_err(done_err),
      .spi_select(spi_select), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
      .spi_read_n(spi_read_n), .spi_write_n(spi_write_n), .spi_rdata(spi_rdata)
   );

   // ---------------- SPI master core model ----------------
   logic [7:0]  c_rx, c_sh;
   logic        c_rrdy, c_roe, c_tmt;
   logic [15:0] c_ctrl, c_ss;
   int          shift_cnt, tx_writes, ctrl_writes, sso_viol;
   logic        sel_q, wr_q, rd_q, force_roe = 1'b0;
   int          acc_log[$];
   logic [15:0] c_status;

   assign c_status = {8'h00, c_rrdy, c_tmt, c_tmt, 1'b0, c_roe, 3'b000};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         c_rx <= 0; c_sh <= 0; c_rrdy <= 0; c_roe <= 0; c_tmt <= 1;
         c_ctrl <= 0; c_ss <= 0; shift_cnt <= 0; spi_rdata <= 0;
         sel_q <= 0; wr_q <= 0; rd_q <= 0;
      end else begin
         sel_q <= spi_select;
         wr_q  <= spi_select && !spi_write_n;
         rd_q  <= spi_select && !spi_read_n;
         if (spi_select && !sel_q) acc_log.push_back(int'(spi_addr));
         if (shift_cnt > 0) begin
            shift_cnt <= shift_cnt - 1;
            if (shift_cnt == 1) begin
               c_rx <= c_sh;
               if (c_rrdy) c_roe <= 1'b1;
               c_rrdy <= 1'b1;
               c_tmt  <= 1'b1;
            end
         end
         if (force_roe) c_roe <= 1'b1;
         if (spi_select && !spi_read_n) begin
            case (spi_addr)
               3'd0: spi_rdata <= {8'h00, c_rx};
               3'd2: spi_rdata <= c_status;
               3'd3: spi_rdata <= c_ctrl;
               3'd5: spi_rdata <= c_ss;
               default: spi_rdata <= 16'd0;
            endcase
            if (!rd_q && spi_addr == 3'd0) c_rrdy <= 1'b0;
         end
         if (spi_select && !spi_write_n && !wr_q) begin
            case (spi_addr)
               3'd1: begin
                  c_sh <= spi_wdata[7:0]; shift_cnt <= 16; c_tmt <= 1'b0;
                  tx_writes <= tx_writes + 1;
                  if (!c_ctrl[10]) sso_viol <= sso_viol + 1;
               end
               3'd2: begin c_roe <= 1'b0; c_rrdy <= 1'b0; end
               3'd3: begin c_ctrl <= spi_wdata; ctrl_writes <= ctrl_writes + 1; end
               3'd5: c_ss <= spi_wdata;
               default: ;
            endcase
         end
      end
   end

   initial begin tx_writes = 0; ctrl_writes = 0; sso_viol = 0; end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string name);
      check(name,
            {28'd0, cmd_ready, spi_select, spi_read_n, spi_write_n, spi_addr, spi_wdata,
             rx_data, tx_ready, rx_valid, busy, done, done_err},
            {28'd0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 16'd0, 8'd0, 5'd0});
   endtask

   typedef struct {
      int         nb;
      logic [7:0] first;
      int         hold_idx;
      int         hold_cyc;
      int         roe_idx;
      bit         preset_roe;
      bit         spam_cmd;
      bit         exp_err;
   } vec_t;

   logic [7:0] sb[$];

   task automatic run_xfer(input vec_t v, input string name);
      int cyc = 0, sent = 0, got = 0, hold = 0, first_tx = -1, txw0 = 0, cw0;
      bit fin = 0, stable = 1;
      logic [7:0] held = 8'h00;
      sb.delete();
      if (v.preset_roe) begin
         force_roe = 1'b1; @(negedge clk); force_roe = 1'b0;
      end
      cw0 = ctrl_writes;
      acc_log.delete();
      cmd_valid = 1'b1; cmd_len = 8'(v.nb - 1); cmd_ss = 16'h0001;
      @(negedge clk);
      check({name, "_accept"}, {busy, cmd_ready}, 2'b10);
      if (v.spam_cmd) cmd_len = 8'hFF; else cmd_valid = 1'b0;
      while (!fin && cyc < 20000) begin
         force_roe = 1'b0;
         if (tx_ready && sent < v.nb) begin
            if (first_tx < 0) first_tx = cyc;
            tx_valid = 1'b1; tx_data = v.first + 8'(sent);
            sb.push_back(tx_data); sent++;
         end else tx_valid = 1'b0;
         if (rx_valid) begin
            if (got == v.hold_idx && hold < v.hold_cyc) begin
               if (hold == 0) begin held = rx_data; txw0 = tx_writes; end
               else if (rx_data !== held) stable = 0;
               hold++; rx_ready = 1'b0;
            end else begin
               rx_ready = 1'b1;
               if (got == v.hold_idx && v.hold_cyc > 0) begin
                  check({name, "_hold_stable"}, 64'(stable), 64'd1);
                  check({name, "_hold_no_txwrite"}, 64'(tx_writes), 64'(txw0));
               end
               if (sb.size() == 0) check({name, "_rx_unexpected"}, 64'(rx_data), 64'h100);
               else check({name, "_rx_byte"}, 64'(rx_data), 64'(sb.pop_front()));
               if (got == v.roe_idx) force_roe = 1'b1;
               got++;
            end
         end else rx_ready = 1'b1;
         if (v.spam_cmd && cyc == 20) check({name, "_cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
         if (done) begin
            fin = 1;
            cmd_valid = 1'b0;
            check({name, "_done_err"}, 64'(done_err), 64'(v.exp_err));
            check({name, "_c_ctrl_off"}, 64'(c_ctrl), 64'd0);
         end
         @(negedge clk); cyc++;
      end
      tx_valid = 1'b0; rx_ready = 1'b1; cmd_valid = 1'b0;
      check({name, "_finished"}, 64'(fin), 64'd1);
      check({name, "_setup_latency"}, 64'(first_tx), 64'd9);
      check({name, "_bytes"}, 64'(got), 64'(v.nb));
      check({name, "_ctrl_writes"}, 64'(ctrl_writes - cw0), 64'd2);
      check({name, "_sso_held"}, 64'(sso_viol), 64'd0);
      check({name, "_done_pulse_idle"}, {61'd0, done, busy, cmd_ready}, 64'b001);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vec_t vecs[7];
      vec_t post;
      logic [31:0] seq;
      int last, n, txw;
      vecs[0] = '{1,   8'hA5, -1, 0,  -1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4,   8'h01, -1, 0,  -1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{4,   8'h10,  1, 50, -1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{3,   8'h80, -1, 0,  -1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{2,   8'h40, -1, 0,   0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{3,   8'hFE, -1, 0,  -1, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{256, 8'h00, -1, 0,  -1, 1'b0, 1'b0, 1'b0};
      post    = '{2,   8'h5A, -1, 0,  -1, 1'b0, 1'b0, 1'b0};

      repeat (2) @(negedge clk);
      check_reset_vals("reset_values");
      rst = 1'b0;
      @(negedge clk);
      check_reset_vals("idle_after_reset");

      for (int i = 0; i < 7; i++) begin
         run_xfer(vecs[i], $sformatf("vec%0d", i));
         if (i == 0) begin
            seq = 32'd0; last = -1;
            foreach (acc_log[k]) if (acc_log[k] != last) begin
               seq = (seq << 4) | 32'(acc_log[k]); last = acc_log[k];
            end
            check("vec0_access_sequence", 64'(seq), 64'h53212023);
         end
         repeat (3) @(negedge clk);
      end

      // Reset while polling for RRDY, then a clean transfer.
      txw = tx_writes;
      cmd_valid = 1'b1; cmd_len = 8'd0; cmd_ss = 16'h0002;
      @(negedge clk); cmd_valid = 1'b0;
      n = 0;
      while (!tx_ready && n < 50) begin @(negedge clk); n++; end
      check("rst_wait_tx_ready", 64'(tx_ready), 64'd1);
      tx_valid = 1'b1; tx_data = 8'h3C;
      @(negedge clk); tx_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("rst_in_poll_r", {62'd0, rx_valid, busy}, 64'b01);
      check("rst_tx_written", 64'(tx_writes), 64'(txw + 1));
      #2 rst = 1'b1;
      #1 check_reset_vals("reset_mid_poll");
      check("reset_core_sso", 64'(c_ctrl), 64'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      run_xfer(post, "after_reset");

`ifdef SPI_SEQ_TIMEOUT_EN
      // tx_valid never offered: watchdog ends the transfer with an error.
      txw = tx_writes;
      cmd_valid = 1'b1; cmd_len = 8'd3; cmd_ss = 16'h0001;
      @(negedge clk); cmd_valid = 1'b0;
      n = 0;
      while (!tx_ready && n < 50) begin @(negedge clk); n++; end
      n = 0;
      while (!done && n < 500) begin @(negedge clk); n++; end
      check("tmo_done", 64'(done), 64'd1);
      check("tmo_done_err", 64'(done_err), 64'd1);
      check("tmo_window", 64'(n >= 60 && n <= 75), 64'd1);
      check("tmo_ctrl_off", 64'(c_ctrl), 64'd0);
      check("tmo_no_txwrite", 64'(tx_writes), 64'(txw));
      @(negedge clk);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
